// File: rtl/mem_bank_responder.sv
// rtl/mem_bank_responder.sv - four-bank word memory with per-bank busy windows and a two-stage read path
module mem_bank_responder #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int WORDS = 4 << DEPTH_LOG2;

    logic [15:0]           mem_q [WORDS];
    logic [2:0]            cnt_q [4];
    logic [15:0]           stage_q;
    logic                  stage_vld_q;
    logic [15:0]           dout_q;

    logic [1:0]            bank;
    logic [DEPTH_LOG2+1:0] waddr;
    logic                  legal;
    logic                  accept;
    logic                  unused_addr_hi;

    assign bank           = addr[2:1];
    assign waddr          = {bank, addr[DEPTH_LOG2+2:3]};
    assign unused_addr_hi = ^addr[15:DEPTH_LOG2+3];

    assign legal    = (rd ^ wr) & ~addr[0];
    assign err      = (rd & wr) | ((rd | wr) & addr[0]);
    assign stall    = legal & busy[bank];
    // Gating with rst_n keeps the unreset array from being written during reset.
    assign accept   = legal & ~busy[bank] & rst_n;
    assign data_out = dout_q;

    always_comb begin
        busy = '0;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt_q[b] != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem_q[waddr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= 3'd0;
            end
            stage_q     <= 16'h0000;
            stage_vld_q <= 1'b0;
            dout_q      <= 16'h0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt_q[b] <= 3'd4;
                end else if (cnt_q[b] != 3'd0) begin
                    cnt_q[b] <= cnt_q[b] - 3'd1;
                end
            end
            stage_vld_q <= accept & rd;
            if (accept && rd) begin
                stage_q <= mem_q[waddr];
            end
            // data_out only moves when a read result arrives; writes never touch it.
            if (stage_vld_q) begin
                dout_q <= stage_q;
            end
        end
    end

endmodule

// File: doc/mem_bank_responder.md
MEM_BANK_RESPONDER -- requirements
Module: mem_bank_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, log2 of words per bank (256 words x 16 bits per bank).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: addr  input  16  byte address; addr[0] alignment bit, addr[2:1] bank select, addr[DEPTH_LOG2+2:3] word index.
REQ-005 Port: data_in  input  16  write data.
REQ-006 Port: wr  input  1  write request, level, sampled each cycle.
REQ-007 Port: rd  input  1  read request, level, sampled each cycle.
REQ-008 Port: data_out  output  16  read data, registered.
REQ-009 Port: stall  output  1  combinational; request targets a busy bank and is not accepted.
REQ-010 Port: busy  output  4  per-bank busy flags, bit b = bank b.
REQ-011 Port: err  output  1  combinational; illegal request this cycle.

Function
REQ-012 Legal request: exactly one of rd/wr high and addr[0]=0.
REQ-013 err SHALL be 1 when rd&wr, or when (rd|wr)&addr[0]; else 0.
REQ-014 Accept condition: legal request and busy[addr[2:1]]=0; accepted at the rising edge ending the request cycle (cycle 0).
REQ-015 stall SHALL be 1 when the request is legal and busy[addr[2:1]]=1; a stalled or erroring request SHALL change no state.
REQ-016 Each bank SHALL own a 3-bit down-counter; on accept the counter loads 4; nonzero counters decrement by 1 every cycle; busy[b] = (count_b != 0).
REQ-017 After accept in cycle 0, busy[b] SHALL be 1 in cycles 1-4 and 0 in cycle 5; a new request to bank b is accepted from cycle 5.
REQ-018 Banks SHALL be independent: a legal request to a non-busy bank is accepted in any cycle regardless of other banks' busy state.
REQ-019 Write: on accept, data_in SHALL be stored at (bank, index) at the cycle-0 edge.
REQ-020 Read: array SHALL be read at the cycle-0 edge into a stage register; at the cycle-1 edge stage moves to data_out; data_out valid from cycle 2.
REQ-021 data_out SHALL hold its last read result until the next read reaches it; writes SHALL never change data_out.
REQ-022 Two reads to different banks accepted in consecutive cycles SHALL produce results in data_out in consecutive cycles in request order.
REQ-023 A write accepted in a cycle where a read to another bank is in the pipeline SHALL not alter that read's result.
REQ-024 Read of a never-written word SHALL return the array's current content (unspecified, not X-filtered).
REQ-025 Throughput: at most one accept per cycle; peak four accepts in four consecutive cycles across four banks.

Reset
REQ-026 While rst_n=0: all bank counters 0, busy=4'b0000, read stage cleared, data_out=16'h0000.
REQ-027 stall and err remain purely combinational during reset; no request is accepted while rst_n=0.
REQ-028 Reset asserted mid-operation SHALL abort in-flight reads (no result delivered) and clear busy immediately; array contents SHALL be retained.
REQ-029 First accept possible in the first cycle with rst_n=1.

Verification
REQ-030 wr addr=16'h0010 data_in=16'hBEEF, then 5 cycles later rd addr=16'h0010 -> busy[0]=1 cycles 1-4, read accepted cycle 5, data_out=16'hBEEF from cycle 7.
REQ-031 wr addr=16'h0002 cycle 0, rd addr=16'h0002 cycle 1 -> stall=1 cycles 1-4 with busy[1]=1, accepted cycle 5, stall=0.
REQ-032 rd addrs 16'h0000,16'h0002,16'h0004,16'h0006 in cycles 0-3 (pre-written 1,2,3,4) -> no stall, busy=4'b1111 in cycle 4, data_out=1,2,3,4 in cycles 2-5.
REQ-033 rd&wr high, addr=16'h0008 -> err=1, stall=0, busy unchanged; rd addr=16'h0009 -> err=1, no accept.
REQ-034 rd addr=16'h0010 accepted, rst_n=0 in cycle 1 -> busy=0 and data_out=0 immediately, no result delivered; after release read again returns pre-reset stored value.
